stage_5: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline; consumes the EX-stage outputs.
- Holds the EX/MEM pipeline register, the word-addressed data memory, branch resolution (PCSrc) and the MEM/WB pipeline register.
- Feeds the write-back path and the IF-stage PC mux, and exposes the EX/MEM and MEM/WB destination info to the hazard/forwarding unit.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/data_mem.sv | 24 ++
 rtl/stage_5.sv | 102 ++++++++++
 tb/tb_stage_5.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths and pipeline-register bundles for the MIPS MEM stage.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     store_data;
    logic [DATA_W-1:0]     alu;
    logic                  zero;
  } ex_mem_t;

  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } mem_wb_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, combinational read.
module data_mem
  import mips_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Read sees the pre-write contents when the same index is written this edge.
  assign rdata = mem[idx];

endmodule

// File: rtl/stage_5.sv
// MEM stage: EX/MEM register, data memory access, branch resolution, MEM/WB register.
module stage_5
  import mips_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     new_PC,
  input  logic                  new_mem_to_reg,
  input  logic                  new_reg_write,
  input  logic                  new_mem_read,
  input  logic                  new_mem_write,
  input  logic                  new_branch,
  input  logic [REG_ADDR_W-1:0] new_rt,
  input  logic [DATA_W-1:0]     new_data_out2,
  input  logic [DATA_W-1:0]     stage_4_ALU,
  input  logic                  stage_4_zero,
  output logic                  pc_src,
  output logic [DATA_W-1:0]     branch_target,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic [DATA_W-1:0]     mem_alu,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  misalign
);

  logic [EX_MEM_W-1:0] ex_mem_q;
  logic [MEM_WB_W-1:0] mem_wb_q;
  ex_mem_t             em, em_next;
  mem_wb_t             wb, wb_next;
  logic [DATA_W-1:0]   rdata;
  logic                mem_we;

  assign em = ex_mem_t'(ex_mem_q);
  assign wb = mem_wb_t'(mem_wb_q);

  always_comb begin
    em_next            = '0;
    em_next.pc         = new_PC;
    em_next.rd         = new_rt;
    em_next.store_data = new_data_out2;
    em_next.alu        = stage_4_ALU;
    em_next.zero       = stage_4_zero;
    // A bubble keeps the data fields but kills every control bit.
    if (!flush) begin
      em_next.mem_to_reg = new_mem_to_reg;
      em_next.reg_write  = new_reg_write;
      em_next.mem_read   = new_mem_read;
      em_next.mem_write  = new_mem_write;
      em_next.branch     = new_branch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ex_mem_q <= '0;
    else if (flush || !stall)  ex_mem_q <= em_next;
  end

  assign misalign = (em.mem_read | em.mem_write) & (em.alu[1:0] != 2'b00);
  assign mem_we   = em.mem_write & ~stall & ~misalign & rst_n;

  data_mem #(
    .DEPTH     (DMEM_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (em.alu[ADDR_BITS+1:2]),
    .wdata (em.store_data),
    .rdata (rdata)
  );

  always_comb begin
    wb_next           = '0;
    wb_next.rd        = em.rd;
    wb_next.reg_write = em.reg_write & (em.rd != '0);
    if (em.mem_read && misalign) wb_next.data = '0;
    else if (em.mem_to_reg)      wb_next.data = rdata;
    else                         wb_next.data = em.alu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mem_wb_q <= '0;
    else if (!stall) mem_wb_q <= wb_next;
  end

  assign pc_src        = em.branch & em.zero;
  assign branch_target = em.pc;
  assign mem_rd        = em.rd;
  assign mem_reg_write = em.reg_write;
  assign mem_alu       = em.alu;
  assign wb_rd         = wb.rd;
  assign wb_reg_write  = wb.reg_write;
  assign wb_data       = wb.data;

endmodule

// File: tb/tb_stage_5.sv
// Self-checking bench for stage_5: vector table with a write-back scoreboard plus hand sequences.
module tb_stage_5;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic [31:0] new_PC, new_data_out2, stage_4_ALU;
  logic        new_mem_to_reg, new_reg_write, new_mem_read, new_mem_write, new_branch;
  logic [4:0]  new_rt;
  logic        stage_4_zero;
  logic        pc_src, mem_reg_write, wb_reg_write, misalign;
  logic [31:0] branch_target, mem_alu, wb_data;
  logic [4:0]  mem_rd, wb_rd;

  stage_5 dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .new_PC(new_PC), .new_mem_to_reg(new_mem_to_reg), .new_reg_write(new_reg_write),
    .new_mem_read(new_mem_read), .new_mem_write(new_mem_write), .new_branch(new_branch),
    .new_rt(new_rt), .new_data_out2(new_data_out2), .stage_4_ALU(stage_4_ALU),
    .stage_4_zero(stage_4_zero), .pc_src(pc_src), .branch_target(branch_target),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu(mem_alu),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [31:0] pc;
    logic        m2r, rw, mr, mw, br;
    logic [4:0]  rt;
    logic [31:0] d2, alu;
    logic        z;
    logic        e_pcsrc, e_mis, e_wrw;
    logic [31:0] e_wdata;
    logic        chk;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk;
  } wb_exp_t;

  wb_exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  function automatic vec_t mk(input logic fl, input logic [31:0] pc,
                              input logic m2r, input logic rw, input logic mr,
                              input logic mw, input logic br, input logic [4:0] rt,
                              input logic [31:0] d2, input logic [31:0] alu, input logic z,
                              input logic ep, input logic em, input logic ew,
                              input logic [31:0] ed, input logic ck);
    vec_t v;
    v.fl = fl; v.pc = pc; v.m2r = m2r; v.rw = rw; v.mr = mr; v.mw = mw; v.br = br;
    v.rt = rt; v.d2 = d2; v.alu = alu; v.z = z;
    v.e_pcsrc = ep; v.e_mis = em; v.e_wrw = ew; v.e_wdata = ed; v.chk = ck;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    flush = v.fl; new_PC = v.pc; new_mem_to_reg = v.m2r; new_reg_write = v.rw;
    new_mem_read = v.mr; new_mem_write = v.mw; new_branch = v.br; new_rt = v.rt;
    new_data_out2 = v.d2; stage_4_ALU = v.alu; stage_4_zero = v.z;
  endtask

  // One unstalled instruction: check EX/MEM-side outputs after its edge and the
  // write-back of the previous instruction from the scoreboard.
  task automatic step(input vec_t v);
    wb_exp_t e;
    stall = 1'b0;
    drive(v);
    @(posedge clk); #1;
    chk("pc_src", {31'd0, pc_src}, {31'd0, v.e_pcsrc});
    chk("misalign", {31'd0, misalign}, {31'd0, v.e_mis});
    chk("mem_reg_write", {31'd0, mem_reg_write}, {31'd0, v.rw & ~v.fl});
    if (!v.fl) begin
      chk("branch_target", branch_target, v.pc);
      chk("mem_rd", {27'd0, mem_rd}, {27'd0, v.rt});
      chk("mem_alu", mem_alu, v.alu);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
      if (e.chk) begin
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
    e.rd = v.rt; e.rw = v.e_wrw; e.data = v.e_wdata; e.chk = v.chk;
    sb.push_back(e);
    $display("txn %0d: alu=0x%08h rt=%0d pc_src=%0b misalign=%0b wb_rd=%0d wb_we=%0b wb_data=0x%08h",
             txn, v.alu, v.rt, pc_src, misalign, wb_rd, wb_reg_write, wb_data);
    txn++;
  endtask

  vec_t tbl[17];
  vec_t nop;

  initial begin
    tbl[0]  = mk(0, 32'h0,  0,0,0,1,0, 5'd0,  32'hDEADBEEF, 32'h10,  0, 0,0,0, 32'h10, 1);
    tbl[1]  = mk(0, 32'h0,  1,1,1,0,0, 5'd8,  32'h0,        32'h10,  0, 0,0,1, 32'hDEADBEEF, 1);
    tbl[2]  = mk(0, 32'h40, 0,0,0,0,1, 5'd0,  32'h0,        32'h0,   1, 1,0,0, 32'h0, 1);
    tbl[3]  = mk(0, 32'h80, 0,0,0,0,1, 5'd0,  32'h0,        32'h4,   0, 0,0,0, 32'h4, 1);
    tbl[4]  = mk(0, 32'h0,  0,0,0,1,0, 5'd0,  32'h1111,     32'h20,  0, 0,0,0, 32'h20, 1);
    tbl[5]  = mk(1, 32'h60, 1,1,0,1,1, 5'd3,  32'h5,        32'h20,  1, 0,0,0, 32'h0, 0);
    tbl[6]  = mk(0, 32'h0,  1,1,1,0,0, 5'd9,  32'h0,        32'h20,  0, 0,0,1, 32'h1111, 1);
    tbl[7]  = mk(0, 32'h0,  0,1,0,0,0, 5'd0,  32'h0,        32'h1234,0, 0,0,0, 32'h1234, 1);
    tbl[8]  = mk(0, 32'h0,  0,1,0,0,0, 5'd5,  32'h0,        32'hCAFE,0, 0,0,1, 32'hCAFE, 1);
    tbl[9]  = mk(0, 32'h0,  0,0,0,1,0, 5'd0,  32'hA5A5,     32'h400, 0, 0,0,0, 32'h400, 1);
    tbl[10] = mk(0, 32'h0,  1,1,1,0,0, 5'd10, 32'h0,        32'h0,   0, 0,0,1, 32'hA5A5, 1);
    tbl[11] = mk(0, 32'h0,  0,0,0,1,0, 5'd0,  32'hBAD,      32'h13,  0, 0,1,0, 32'h13, 1);
    tbl[12] = mk(0, 32'h0,  1,1,1,0,0, 5'd11, 32'h0,        32'h13,  0, 0,1,1, 32'h0, 1);
    tbl[13] = mk(0, 32'h0,  1,1,1,0,0, 5'd12, 32'h0,        32'h10,  0, 0,0,1, 32'hDEADBEEF, 1);
    tbl[14] = mk(0, 32'h0,  1,1,0,1,0, 5'd13, 32'h77,       32'h10,  0, 0,0,1, 32'hDEADBEEF, 1);
    tbl[15] = mk(0, 32'h0,  1,1,1,0,0, 5'd14, 32'h0,        32'h10,  0, 0,0,1, 32'h77, 1);
    tbl[16] = mk(0, 32'h0,  0,0,0,0,0, 5'd0,  32'h0,        32'h0,   0, 0,0,0, 32'h0, 1);
    nop = tbl[16];

    rst_n = 1'b0; stall = 1'b0;
    drive(nop);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc_src", {31'd0, pc_src}, 32'd0);
    chk("reset_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_branch_target", branch_target, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) step(tbl[i]);
    sb.delete();

    // Stall during a store: memory write and MEM/WB both wait for the stall to drop.
    step(mk(0, 32'h0, 0,0,0,1,0, 5'd0, 32'h11, 32'h30, 0, 0,0,0, 32'h30, 1));
    step(mk(0, 32'h0, 0,1,0,0,0, 5'd7, 32'h0,  32'h99, 0, 0,0,1, 32'h99, 1));
    step(mk(0, 32'h0, 0,0,0,1,0, 5'd0, 32'h55, 32'h30, 0, 0,0,0, 32'h30, 1));
    chk("mem12_before_stall", dut.u_mem.mem[12], 32'h11);
    drive(mk(0, 32'h0, 1,1,1,0,0, 5'd20, 32'h0, 32'h44, 0, 0,0,0, 32'h0, 0));
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("stall_mem12", dut.u_mem.mem[12], 32'h11);
      chk("stall_mem_alu", mem_alu, 32'h30);
      chk("stall_wb_rd", {27'd0, wb_rd}, 32'd7);
      chk("stall_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
      chk("stall_wb_data", wb_data, 32'h99);
      $display("txn %0d: stall cycle %0d mem_alu=0x%08h wb_data=0x%08h", txn, c, mem_alu, wb_data);
      txn++;
    end
    step(nop);
    chk("mem12_after_stall", dut.u_mem.mem[12], 32'h55);

    // Asynchronous reset mid-stream with a taken branch in EX/MEM.
    step(mk(0, 32'h44, 0,0,0,0,1, 5'd0, 32'h0, 32'h0, 1, 1,0,0, 32'h0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc_src", {31'd0, pc_src}, 32'd0);
    chk("async_branch_target", branch_target, 32'd0);
    chk("async_misalign", {31'd0, misalign}, 32'd0);
    chk("async_mem_rd", {27'd0, mem_rd}, 32'd0);
    chk("async_mem_alu", mem_alu, 32'd0);
    chk("async_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("async_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("async_wb_data", wb_data, 32'd0);
    drive(mk(0, 32'h0, 0,0,0,1,0, 5'd0, 32'hFFFF, 32'h10, 0, 0,0,0, 32'h0, 0));
    repeat (2) @(posedge clk);
    #1;
    drive(nop);
    rst_n = 1'b1;
    $display("txn %0d: reset pulse done", txn);
    txn++;
    sb.delete();
    step(mk(0, 32'h0, 1,1,1,0,0, 5'd15, 32'h0, 32'h10, 0, 0,0,1, 32'h77, 1));
    step(nop);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
